// File: rtl/slot_arb_pkg.sv
// Shared types for the Z80 / HPS-loader slot datapath arbiter.
package slot_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CPU       = 2'd1,
    ST_LD_ACCESS = 2'd2,
    ST_LD_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_CPU    = 2'd0,
    OWN_LOADER = 2'd1,
    OWN_NONE   = 2'd2
  } own_t;

  // Writes here would hit the subslot expander register, so loader beats to it are refused.
  localparam logic [15:0] EXPANDER_ADDR = 16'hFFFF;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  slot;
    logic [1:0]  subslot;
  } ld_beat_t;

  function automatic logic is_expander_addr(input logic [15:0] addr);
    return (addr == EXPANDER_ADDR);
  endfunction

endpackage

// File: rtl/slot_arb_mux.sv
// Combinational selection of the datapath request between the live CPU bus
// and the latched loader beat.
module slot_arb_mux
  import slot_arb_pkg::*;
(
  input  own_t        own,
  input  logic        cpu_mreq,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [1:0]  cpu_slot,
  input  logic [1:0]  cpu_subslot,
  input  ld_beat_t    beat,
  output logic        sel_mreq,
  output logic        sel_rd,
  output logic        sel_wr,
  output logic [15:0] sel_addr,
  output logic [7:0]  sel_wdata,
  output logic [1:0]  sel_slot,
  output logic [1:0]  sel_subslot
);

  // Ownership mux; the dead cycle after a beat drives an idle request.
  always_comb begin
    sel_mreq    = 1'b0;
    sel_rd      = 1'b0;
    sel_wr      = 1'b0;
    sel_addr    = 16'h0000;
    sel_wdata   = 8'h00;
    sel_slot    = 2'd0;
    sel_subslot = 2'd0;
    case (own)
      OWN_CPU: begin
        sel_mreq    = cpu_mreq;
        sel_rd      = cpu_rd;
        sel_wr      = cpu_wr;
        sel_addr    = cpu_addr;
        sel_wdata   = cpu_wdata;
        sel_slot    = cpu_slot;
        sel_subslot = cpu_subslot;
      end
      OWN_LOADER: begin
        sel_mreq    = 1'b1;
        sel_rd      = ~beat.wr;
        sel_wr      = beat.wr;
        sel_addr    = beat.addr;
        sel_wdata   = beat.wdata;
        sel_slot    = beat.slot;
        sel_subslot = beat.subslot;
      end
      default: begin
        sel_mreq    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/slot_access_arbiter.sv
// Arbitrates the slot/subslot memory datapath between the Z80 bus and the
// HPS ROM/RAM loader, stalling the CPU while a loader beat owns it.
module slot_access_arbiter
  import slot_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MAX_CPU_RUN   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mreq,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [1:0]  cpu_slot,
  input  logic [1:0]  cpu_subslot,
  output logic        cpu_wait,
  input  logic        ld_req,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic [1:0]  ld_slot,
  input  logic [1:0]  ld_subslot,
  output logic        ld_ack,
  output logic        ld_err,
  output logic [7:0]  ld_rdata,
  output logic        sel_mreq,
  output logic        sel_rd,
  output logic        sel_wr,
  output logic [15:0] sel_addr,
  output logic [7:0]  sel_wdata,
  output logic [1:0]  sel_slot,
  output logic [1:0]  sel_subslot,
  output logic        sel_loader,
  input  logic [7:0]  sel_rdata
);

  localparam logic [7:0] RUN_MAX   = 8'(MAX_CPU_RUN);
  localparam logic [3:0] BEAT_LAST = 4'(ACCESS_CYCLES - 1);

  arb_state_t state_r;
  arb_state_t state_next_s;
  logic [7:0] run_cnt_r;
  logic [3:0] beat_cnt_r;
  ld_beat_t   beat_r;
  logic       ld_ack_r;
  logic       ld_err_r;
  logic [7:0] ld_rdata_r;
  logic       accept_s;
  logic       force_s;
  logic       cpu_wait_s;
  own_t       own_s;

  // A forced beat may only start once the CPU strobe has gone idle.
  assign force_s = ld_req && (run_cnt_r == RUN_MAX) && !cpu_rd && !cpu_wr;

  // Next-state, ownership and CPU stall decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    cpu_wait_s   = 1'b0;
    own_s        = OWN_CPU;
    case (state_r)
      ST_IDLE: begin
        if (ld_req && (!cpu_mreq || force_s)) begin
          accept_s   = 1'b1;
          cpu_wait_s = cpu_mreq;
        end else if (cpu_mreq) begin
          state_next_s = ST_CPU;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CPU: begin
        if (force_s) begin
          accept_s   = 1'b1;
          cpu_wait_s = cpu_mreq;
        end else if (!cpu_mreq) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CPU;
        end
      end
      ST_LD_ACCESS: begin
        own_s      = OWN_LOADER;
        cpu_wait_s = cpu_mreq;
        if (beat_cnt_r == 4'd0) begin
          state_next_s = ST_LD_DONE;
        end else begin
          state_next_s = ST_LD_ACCESS;
        end
      end
      ST_LD_DONE: begin
        own_s        = OWN_NONE;
        state_next_s = ST_IDLE;
      end
      default: begin
        own_s        = OWN_NONE;
        state_next_s = ST_IDLE;
      end
    endcase
    if (accept_s) begin
      state_next_s = is_expander_addr(ld_addr) ? ST_LD_DONE : ST_LD_ACCESS;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State, counters, latched beat and loader response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      run_cnt_r  <= 8'd0;
      beat_cnt_r <= 4'd0;
      beat_r     <= '0;
      ld_ack_r   <= 1'b0;
      ld_err_r   <= 1'b0;
      ld_rdata_r <= 8'h00;
    end else begin
      state_r  <= state_next_s;
      ld_ack_r <= (state_next_s == ST_LD_DONE);
      ld_err_r <= accept_s && is_expander_addr(ld_addr);
      if (accept_s) begin
        beat_r     <= '{wr: ld_wr, addr: ld_addr, wdata: ld_wdata,
                        slot: ld_slot, subslot: ld_subslot};
        beat_cnt_r <= BEAT_LAST;
      end else if (state_r == ST_LD_ACCESS && beat_cnt_r != 4'd0) begin
        beat_cnt_r <= beat_cnt_r - 4'd1;
      end
      if (state_r == ST_LD_ACCESS && beat_cnt_r == 4'd0 && !beat_r.wr) begin
        ld_rdata_r <= sel_rdata;
      end
      if (state_r == ST_LD_DONE || !ld_req) begin
        run_cnt_r <= 8'd0;
      end else if (state_r == ST_CPU && run_cnt_r != RUN_MAX) begin
        run_cnt_r <= run_cnt_r + 8'd1;
      end
    end
  end

  slot_arb_mux u_mux (
    .own         (own_s),
    .cpu_mreq    (cpu_mreq),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_slot    (cpu_slot),
    .cpu_subslot (cpu_subslot),
    .beat        (beat_r),
    .sel_mreq    (sel_mreq),
    .sel_rd      (sel_rd),
    .sel_wr      (sel_wr),
    .sel_addr    (sel_addr),
    .sel_wdata   (sel_wdata),
    .sel_slot    (sel_slot),
    .sel_subslot (sel_subslot)
  );

  assign sel_loader = (state_r == ST_LD_ACCESS);
  assign cpu_wait   = cpu_wait_s;
  assign ld_ack     = ld_ack_r;
  assign ld_err     = ld_err_r;
  assign ld_rdata   = ld_rdata_r;

endmodule

// File: tb/tb_slot_access_arbiter.sv
// Scoreboard bench for slot_access_arbiter with ACCESS_CYCLES=2, MAX_CPU_RUN=4.
module tb_slot_access_arbiter;

  localparam int AC = 2;
  localparam int MR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mreq, cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [1:0]  cpu_slot, cpu_subslot;
  logic        cpu_wait;
  logic        ld_req, ld_wr;
  logic [15:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic [1:0]  ld_slot, ld_subslot;
  logic        ld_ack, ld_err;
  logic [7:0]  ld_rdata;
  logic        sel_mreq, sel_rd, sel_wr;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [1:0]  sel_slot, sel_subslot;
  logic        sel_loader;
  logic [7:0]  sel_rdata;

  always #5 clk = ~clk;

  slot_access_arbiter #(.ACCESS_CYCLES(AC), .MAX_CPU_RUN(MR)) dut (
    .clk(clk), .reset(reset),
    .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_slot(cpu_slot), .cpu_subslot(cpu_subslot), .cpu_wait(cpu_wait),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_slot(ld_slot), .ld_subslot(ld_subslot), .ld_ack(ld_ack), .ld_err(ld_err), .ld_rdata(ld_rdata),
    .sel_mreq(sel_mreq), .sel_rd(sel_rd), .sel_wr(sel_wr), .sel_addr(sel_addr),
    .sel_wdata(sel_wdata), .sel_slot(sel_slot), .sel_subslot(sel_subslot),
    .sel_loader(sel_loader), .sel_rdata(sel_rdata)
  );

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] rdata_model = 8'h00;

  // starvation scenario: per-cycle CPU read strobe and expected wait/owner/ack
  bit st_rd   [0:10] = '{1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  bit st_wait [0:10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
  bit st_load [0:10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  bit st_ack  [0:10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic [7:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: every ld_ack pops one expected response.
  always @(negedge clk) begin
    if (ld_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(ld_ack), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_err", 32'(ld_err), 32'(mon_e.err));
        check("ack_rdata", 32'(ld_rdata), 32'(mon_e.rdata));
      end
    end
  end

  task automatic beat(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                      input logic [1:0] slot, input logic [1:0] sub, input logic [7:0] rd_val,
                      input logic exp_err, input int exp_lat, input int exp_strobes);
    int k = 0;
    int strobes = 0;
    bit seen = 0;
    bit wait_seen = 0;
    bit field_bad = 0;
    @(posedge clk); #1;
    ld_wr = wr; ld_addr = addr; ld_wdata = wdata; ld_slot = slot; ld_subslot = sub;
    sel_rdata = rd_val; ld_req = 1'b1;
    if (!exp_err && !wr) rdata_model = rd_val;
    push_exp(exp_err, rdata_model);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (sel_loader) begin
        if (wr ? sel_wr : sel_rd) strobes++;
        if (sel_addr !== addr || sel_wdata !== wdata || sel_slot !== slot ||
            sel_subslot !== sub || sel_mreq !== 1'b1 || (wr ? sel_rd : sel_wr) !== 1'b0)
          field_bad = 1;
      end else if (sel_wr || sel_rd) begin
        field_bad = 1;
      end
      if (cpu_wait) wait_seen = 1;
      if (ld_ack) seen = 1;
    end
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_latency", k - 1, exp_lat);
    check("strobe_cycles", strobes, exp_strobes);
    check("loader_fields", 32'(field_bad), 32'd0);
    check("no_cpu_wait", 32'(wait_seen), 32'd0);
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    cpu_slot = 2'd0; cpu_subslot = 2'd0;
    ld_req = 1'b0; ld_wr = 1'b0; ld_addr = 16'h0000; ld_wdata = 8'h00;
    ld_slot = 2'd0; ld_subslot = 2'd0; sel_rdata = 8'h00;

    @(negedge clk);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_ld_ack", 32'(ld_ack), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_ld_rdata", 32'(ld_rdata), 32'h00);
    check("rst_sel_loader", 32'(sel_loader), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    beat(1'b1, 16'h4000, 8'hA5, 2'd1, 2'd2, 8'h00, 1'b0, AC + 1, AC);
    beat(1'b0, 16'h8123, 8'h00, 2'd2, 2'd0, 8'h3C, 1'b0, AC + 1, AC);
    beat(1'b1, 16'hFFFF, 8'h5A, 2'd3, 2'd3, 8'h99, 1'b1, 1, 0);
    beat(1'b1, 16'h1000, 8'hC3, 2'd0, 2'd1, 8'h99, 1'b0, AC + 1, AC);

    // CPU request arrives in the first access cycle of a loader read
    @(posedge clk); #1;
    ld_wr = 1'b0; ld_addr = 16'h0010; ld_wdata = 8'h00; ld_slot = 2'd0; ld_subslot = 2'd3;
    sel_rdata = 8'h77; ld_req = 1'b1;
    rdata_model = 8'h77;
    push_exp(1'b0, rdata_model);
    @(posedge clk); #1;
    cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h1234; cpu_slot = 2'd3; cpu_subslot = 2'd1;
    @(negedge clk);
    check("coll_wait_1", 32'(cpu_wait), 32'd1);
    check("coll_owner_1", 32'(sel_loader), 32'd1);
    check("coll_addr_1", 32'(sel_addr), 32'h0010);
    @(negedge clk);
    check("coll_wait_2", 32'(cpu_wait), 32'd1);
    @(negedge clk);
    check("coll_ack", 32'(ld_ack), 32'd1);
    check("coll_wait_done", 32'(cpu_wait), 32'd0);
    check("coll_sel_idle", 32'(sel_mreq), 32'd0);
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(negedge clk);
    check("coll_cpu_addr", 32'(sel_addr), 32'h1234);
    check("coll_cpu_rd", 32'(sel_rd), 32'd1);
    check("coll_cpu_slot", 32'({sel_slot, sel_subslot}), 32'({2'd3, 2'd1}));
    check("coll_cpu_owner", 32'(sel_loader), 32'd0);
    check("coll_cpu_wait", 32'(cpu_wait), 32'd0);
    @(posedge clk); #1;
    cpu_mreq = 1'b0; cpu_rd = 1'b0;
    @(posedge clk); #1;

    // starvation: CPU holds mreq with pulsing reads while a beat is pending
    ld_wr = 1'b0; ld_addr = 16'h2000; ld_slot = 2'd1; ld_subslot = 2'd1; sel_rdata = 8'h5A;
    rdata_model = 8'h5A;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end else begin
        ld_req = 1'b1; cpu_mreq = 1'b1; cpu_addr = 16'h0100;
        push_exp(1'b0, rdata_model);
      end
      cpu_rd = st_rd[i];
      @(negedge clk);
      check($sformatf("starve_wait_%0d", i), 32'(cpu_wait), 32'(st_wait[i]));
      check($sformatf("starve_owner_%0d", i), 32'(sel_loader), 32'(st_load[i]));
      check($sformatf("starve_ack_%0d", i), 32'(ld_ack), 32'(st_ack[i]));
    end
    @(posedge clk); #1;
    ld_req = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0;
    @(posedge clk); #1;

    // reset during the first access cycle of a write beat
    ld_wr = 1'b1; ld_addr = 16'h5000; ld_wdata = 8'h11; ld_slot = 2'd2; ld_subslot = 2'd1;
    ld_req = 1'b1;
    @(posedge clk); #1;
    cpu_mreq = 1'b1;
    @(negedge clk);
    check("rstmid_sel_wr_before", 32'(sel_wr), 32'd1);
    check("rstmid_wait_before", 32'(cpu_wait), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rstmid_sel_wr", 32'(sel_wr), 32'd0);
    check("rstmid_wait", 32'(cpu_wait), 32'd0);
    check("rstmid_owner", 32'(sel_loader), 32'd0);
    ld_req = 1'b0; cpu_mreq = 1'b0;
    rdata_model = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_rdata", 32'(ld_rdata), 32'h00);
    check("rstmid_owner_after", 32'(sel_loader), 32'd0);

    beat(1'b0, 16'hFFFF, 8'h00, 2'd0, 2'd0, 8'hEE, 1'b1, 1, 0);
    beat(1'b0, 16'h7FFE, 8'h00, 2'd3, 2'd2, 8'hB7, 1'b0, AC + 1, AC);
    beat(1'b1, 16'h7FFF, 8'h42, 2'd3, 2'd2, 8'h00, 1'b0, AC + 1, AC);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slot_access_arbiter.md
Name: slot_access_arbiter

Overview:
- Shares the slot/subslot memory datapath between the Z80 bus and the HPS ROM/RAM loader.
- Drives one muxed request (address, strobes, write data, target slot/subslot) into the slot decode and expander logic.
- Stalls the CPU with cpu_wait while a loader beat owns the datapath.
- Returns read data and a completion pulse to the loader.

Parameters:
- ACCESS_CYCLES, 2, cycles each loader beat holds its strobe on the datapath (1..15).
- MAX_CPU_RUN, 64, consecutive CPU-owned cycles allowed while ld_req is pending before a loader beat is forced (2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_mreq  in  1  CPU memory request
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_slot  in  2  primary slot decoded for cpu_addr
- cpu_subslot  in  2  subslot from the expander for cpu_addr
- cpu_wait  out  1  holds the CPU cycle
- ld_req  in  1  loader beat request, level, held until ld_ack
- ld_wr  in  1  1 = write, 0 = read
- ld_addr  in  16  loader address
- ld_wdata  in  8  loader write data
- ld_slot  in  2  loader target slot
- ld_subslot  in  2  loader target subslot
- ld_ack  out  1  one-cycle beat completion
- ld_err  out  1  qualifies ld_ack: beat rejected
- ld_rdata  out  8  read data, valid with ld_ack
- sel_mreq  out  1  datapath request
- sel_rd  out  1  datapath read strobe
- sel_wr  out  1  datapath write strobe
- sel_addr  out  16  datapath address
- sel_wdata  out  8  datapath write data
- sel_slot  out  2  datapath slot
- sel_subslot  out  2  datapath subslot
- sel_loader  out  1  1 while the loader owns the datapath; expander register write is suppressed
- sel_rdata  in  8  datapath read data

Behaviour:
- Reset: state IDLE, run counter 0, beat counter 0; cpu_wait=0, ld_ack=0, ld_err=0, ld_rdata=8'h00, sel_loader=0.
- Outputs in CPU ownership: sel_* follow the cpu_* inputs combinationally (zero latency). The CPU path is never registered.
- States: IDLE, CPU, LD_ACCESS, LD_DONE.
- IDLE:
  - cpu_mreq has priority: go to CPU.
  - Else, if ld_req: latch the loader fields and check the address.
  - ld_addr==16'hFFFF is rejected: go to LD_DONE with ld_err=1 and no datapath strobe.
  - Any other address: go to LD_ACCESS with the beat counter = ACCESS_CYCLES-1.
- CPU:
  - Return to IDLE when cpu_mreq falls.
  - Run counter increments each cycle while ld_req=1 and saturates at MAX_CPU_RUN; it clears when ld_req=0.
  - When the counter reaches MAX_CPU_RUN, the next loader beat is forced: assert cpu_wait, go to LD_ACCESS at the next cycle the CPU strobe is inactive (cpu_rd=cpu_wr=0). Never cut a CPU strobe mid-cycle.
- LD_ACCESS:
  - sel_* driven from the latched loader fields; sel_loader=1; cpu_wait=cpu_mreq.
  - Beat counter decrements each cycle.
  - At 0: capture sel_rdata into ld_rdata on reads and go to LD_DONE.
- LD_DONE:
  - ld_ack=1 for exactly one cycle; run counter cleared.
  - Next state IDLE. cpu_wait drops that same cycle, so a pending CPU request proceeds next cycle.
- Write beats: ld_rdata is left unchanged.
- Timing: loader beat latency from IDLE acceptance to ld_ack = ACCESS_CYCLES+1 cycles.
- Simultaneous cpu_mreq and ld_req in IDLE: the CPU wins unless the run counter is saturated.
- ld_req dropped mid-beat: the beat still completes and ld_ack pulses (loader must ignore it).
- Reset mid-beat: strobes and cpu_wait drop asynchronously; the latched beat is discarded, no ld_ack.

Decomposition:
- Package slot_arb_pkg:
  - arb_state_t enum.
  - EXPANDER_ADDR = 16'hFFFF.
  - struct ld_beat_t {wr, addr, wdata, slot, subslot}.
- One sub-module, slot_arb_mux: the combinational sel_* mux keyed on ownership.
- FSM and counters live in the top module.

Test Plan:
- Loader write only, ACCESS_CYCLES=2: ld_req, addr 4000h, data A5h, slot 1, subslot 2 -> sel_wr high 2 cycles with those values, sel_loader=1, ld_ack at cycle 3, ld_err=0.
- Loader read: sel_rdata=3Ch -> ld_rdata=3Ch with ld_ack; cpu_wait stays 0.
- Collision: CPU mreq arrives during LD_ACCESS -> cpu_wait=1 until ld_ack cycle; CPU sel_* appear the next cycle unchanged.
- Starvation, MAX_CPU_RUN=4: cpu_mreq held, ld_req pending, CPU strobes pulse -> after 4 CPU cycles, cpu_wait asserts at a strobe-idle cycle and a loader beat completes.
- Expander protection: ld_addr=FFFFh write -> no sel_wr, ld_ack with ld_err=1 on cycle 2.
- Reset asserted in LD_ACCESS cycle 1 -> sel_wr and cpu_wait drop immediately, no ld_ack, state IDLE after release.
